// File: rtl/shared_reg_arbiter_pkg.sv
// Shared constants for the shared-register arbiter: FSM encodings and default sizing.
package shared_reg_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_IDXW  = 2;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping at NREQ.
module shared_reg_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] winner,
  output logic            any_req
);

  int              sum;
  logic [IDXW-1:0] idx;

  // Scan from the farthest offset down so the nearest hit to ptr is the last assignment.
  always_comb begin
    winner  = '0;
    any_req = |req;
    sum     = 0;
    idx     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = int'(ptr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = sum[IDXW-1:0];
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter/sequencer sharing one load-enabled register among NREQ requesters.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDXW  = DEF_IDXW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       wr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  ack,
  output logic [WIDTH-1:0]      rdata,
  output logic                  busy,
  output logic                  reg_load,
  output logic [WIDTH-1:0]      reg_in,
  input  logic [WIDTH-1:0]      reg_out
);

  logic [1:0]       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic             cmd_wr_q, cmd_wr_d;
  logic [WIDTH-1:0] cmd_data_q, cmd_data_d;

  logic [IDXW-1:0]  winner;
  logic             any_req;
  logic             in_access;
  logic             in_resp;

  shared_reg_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    cmd_wr_d   = cmd_wr_q;
    cmd_data_d = cmd_data_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (any_req) begin
          state_d = ST_ACCESS;
          for (int i = 0; i < NREQ; i++) begin
            if (winner == IDXW'(i)) begin
              gnt_d[i]   = 1'b1;
              cmd_wr_d   = wr[i];
              cmd_data_d = wdata[i*WIDTH +: WIDTH];
            end
          end
          // Explicit wrap keeps non-power-of-two NREQ correct.
          ptr_d = (winner == IDXW'(NREQ - 1)) ? '0 : winner + IDXW'(1);
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      ptr_q      <= '0;
      cmd_wr_q   <= 1'b0;
      cmd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      cmd_wr_q   <= cmd_wr_d;
      cmd_data_q <= cmd_data_d;
    end
  end

  // Gating with reset drops reg_load in the same instant reset rises, so an aborted write never lands.
  assign in_access = (state_q == ST_ACCESS) && !reset;
  assign in_resp   = (state_q == ST_RESP) && !reset;

  assign gnt      = gnt_q;
  assign busy     = in_access || in_resp;
  assign reg_load = in_access && cmd_wr_q;
  assign reg_in   = in_access ? cmd_data_q : '0;
  assign ack      = in_resp;
  assign rdata    = in_resp ? reg_out : '0;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Randomized and directed bench for shared_reg_arbiter against a transaction-level model.
module tb_shared_reg_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int IDXW  = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       wr;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic                  ack;
  logic [WIDTH-1:0]      rdata;
  logic                  busy;
  logic                  reg_load;
  logic [WIDTH-1:0]      reg_in;
  logic [WIDTH-1:0]      shreg = 16'h0000;

  int total = 0;
  int bad   = 0;

  // Transaction model: phase 0 waiting, 1 register access, 2 response.
  int               m_phase = 0;
  int               m_win   = 0;
  int               m_ptr   = 0;
  logic             m_wr    = 1'b0;
  logic [WIDTH-1:0] m_data  = '0;
  logic [WIDTH-1:0] m_reg   = '0;

  shared_reg_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .wr       (wr),
    .wdata    (wdata),
    .gnt      (gnt),
    .ack      (ack),
    .rdata    (rdata),
    .busy     (busy),
    .reg_load (reg_load),
    .reg_in   (reg_in),
    .reg_out  (shreg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (reg_load) shreg <= reg_in;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_ptr   = 0;
    m_win   = 0;
    m_wr    = 1'b0;
    m_data  = '0;
  endtask

  task automatic model_edge(input logic [NREQ-1:0] r, input logic [NREQ-1:0] w,
                            input logic [NREQ*WIDTH-1:0] d);
    if (reset) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (r != 0) begin
        for (int k = NREQ - 1; k >= 0; k--)
          if (r[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
        m_wr    = w[m_win];
        m_data  = d[m_win*WIDTH +: WIDTH];
        m_ptr   = (m_win + 1) % NREQ;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (m_wr) m_reg = m_data;
      m_phase = 2;
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] eg;
    eg = '0;
    if (m_phase != 0) eg[m_win] = 1'b1;
    chk_eq("gnt", 32'(gnt), 32'(eg));
    chk_eq("busy", 32'(busy), 32'(m_phase != 0));
    chk_eq("reg_load", 32'(reg_load), 32'(m_phase == 1 && m_wr));
    chk_eq("reg_in", 32'(reg_in), (m_phase == 1) ? 32'(m_data) : 32'h0);
    chk_eq("ack", 32'(ack), 32'(m_phase == 2));
    chk_eq("rdata", 32'(rdata), (m_phase == 2) ? 32'(m_reg) : 32'h0);
    chk_eq("shreg", 32'(shreg), 32'(m_reg));
  endtask

  // Called at a falling edge: check this cycle, drive inputs, advance model across the next rise.
  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] w,
                      input logic [NREQ*WIDTH-1:0] d);
    check_outputs();
    req   = r;
    wr    = w;
    wdata = d;
    model_edge(r, w, d);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0);
  endtask

  function automatic logic [NREQ*WIDTH-1:0] slot(input int i, input logic [WIDTH-1:0] v);
    logic [NREQ*WIDTH-1:0] d;
    d = '0;
    d[i*WIDTH +: WIDTH] = v;
    return d;
  endfunction

  initial begin
    reset = 1'b1;
    req   = 4'b1111;
    wr    = '0;
    wdata = '0;
    @(negedge clk);

    // Reset held with all requests pending.
    for (int i = 0; i < 3; i++) step(4'b1111, '0, '0);
    reset = 1'b0;
    step(4'b1111, '0, '0);
    chk_eq("rst_first_gnt", 32'(gnt), 32'h1);
    idle(3);

    // Single write by requester 2, then read by requester 1.
    step(4'b0100, 4'b0100, slot(2, 16'hBEEF));
    chk_eq("wr_gnt", 32'(gnt), 32'h4);
    chk_eq("wr_in", 32'(reg_in), 32'hBEEF);
    idle(3);
    step(4'b0010, 4'b0000, slot(1, 16'h7777));
    step('0, '0, '0);
    chk_eq("rd_rdata", 32'(rdata), 32'hBEEF);
    idle(2);

    // Fairness from pointer 0: grants 0,1,2,3 three cycles apart.
    reset = 1'b1;
    model_reset();
    step('0, '0, '0);
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step(4'b1111, 4'b0000, '0);
      if ((k - 1) % 3 == 0) chk_eq("fair_order", 32'(gnt), 32'(1 << ((k - 1) / 3)));
    end
    idle(3);

    // Pointer wrap: after 3 came last, 0 then 3.
    for (int k = 1; k <= 6; k++) begin
      step(4'b1001, '0, '0);
      if (k == 1) chk_eq("wrap_first", 32'(gnt), 32'h1);
      if (k == 4) chk_eq("wrap_second", 32'(gnt), 32'h8);
    end
    idle(3);

    // Requester 1 drops req and scrambles data after grant.
    step(4'b0010, 4'b0010, slot(1, 16'h1234));
    step('0, '0, '0);
    chk_eq("drop_ack", 32'(ack), 32'h1);
    chk_eq("drop_reg", 32'(shreg), 32'h1234);
    idle(2);

    // Reset during the ACCESS cycle of a write.
    step(4'b0001, 4'b0001, slot(0, 16'hAAAA));
    idle(3);
    step(4'b0001, 4'b0001, slot(0, 16'h5555));
    check_outputs();
    reset = 1'b1;
    model_reset();
    #1;
    chk_eq("abort_load", 32'(reg_load), 32'h0);
    chk_eq("abort_gnt", 32'(gnt), 32'h0);
    chk_eq("abort_busy", 32'(busy), 32'h0);
    step('0, '0, '0);
    reset = 1'b0;
    step('0, '0, '0);
    chk_eq("abort_reg", 32'(shreg), 32'hAAAA);
    chk_eq("abort_noack", 32'(ack), 32'h0);
    step(4'b1111, '0, '0);
    chk_eq("abort_ptr0", 32'(gnt), 32'h1);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), {$urandom, $urandom});
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
